// File: rtl/replay_stream_buffer.sv
// Load-once / read-many buffer: captures a block of RD words from a wide write stream,
// then replays it on a narrow read stream for a programmable number of passes.
module replay_stream_buffer #(
  parameter  int unsigned WR_WIDTH = 64,
  parameter  int unsigned RD_WIDTH = 32,
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned PASS_W   = 4,
  localparam int unsigned RATIO    = WR_WIDTH / RD_WIDTH,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                start_i,
  input  logic [ADDR_W:0]     len_i,
  input  logic [PASS_W-1:0]   passes_i,
  input  logic [WR_WIDTH-1:0] wr_data_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  output logic [RD_WIDTH-1:0] rd_data_o,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic                rd_last_o,
  output logic [PASS_W-1:0]   pass_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_e;
  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam cnt_t             CNT_ONE  = cnt_t'(1);
  localparam cnt_t             RATIO_C  = cnt_t'(RATIO);
  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

  state_e              state_q, state_d;
  cnt_t                len_q, len_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  cnt_t                wr_cnt_q, wr_cnt_d;
  cnt_t                rd_ptr_q, rd_ptr_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic                done_q, done_d;
  logic [RD_WIDTH-1:0] mem_q [DEPTH];
  logic [RD_WIDTH-1:0] mem_d [DEPTH];

  logic rd_valid, rd_last, push, pop;
  cnt_t rem, n_push;

  // Reads in FILL only see words committed by earlier pushes (registered wr_cnt).
  assign rd_valid = (state_q == REPLAY) ||
                    ((state_q == FILL) && (pass_q == '0) && (rd_ptr_q < wr_cnt_q));
  assign rd_last  = rd_valid && (rd_ptr_q == len_q - CNT_ONE);
  assign push     = (state_q == FILL) && wr_valid_i;
  assign pop      = rd_valid && rd_ready_i;
  assign rem      = len_q - wr_cnt_q;
  assign n_push   = (rem < RATIO_C) ? rem : RATIO_C;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    passes_d = passes_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    mem_d    = mem_q;
    if (flush_i) begin
      state_d  = IDLE;
      wr_cnt_d = '0;
      rd_ptr_d = '0;
      pass_d   = '0;
    end else if (state_q == IDLE) begin
      if (start_i && (len_i != '0) && (passes_i != '0)) begin
        state_d  = FILL;
        len_d    = len_i;
        passes_d = passes_i;
        wr_cnt_d = '0;
        rd_ptr_d = '0;
        pass_d   = '0;
      end
    end else begin
      if (push) begin
        for (int unsigned i = 0; i < RATIO; i++) begin
          if (cnt_t'(i) < n_push)
            mem_d[addr_t'(wr_cnt_q + cnt_t'(i))] = wr_data_i[i*RD_WIDTH +: RD_WIDTH];
        end
        wr_cnt_d = wr_cnt_q + n_push;
        if (wr_cnt_d == len_q) state_d = REPLAY;
      end
      if (pop) begin
        if (rd_last) begin
          rd_ptr_d = '0;
          pass_d   = pass_q + PASS_ONE;
          // Final word of the final pass: pass 0 can only end after the fill, so no push conflict.
          if (pass_q == passes_q - PASS_ONE) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            wr_cnt_d = '0;
            pass_d   = '0;
          end
        end else begin
          rd_ptr_d = rd_ptr_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      len_q    <= '0;
      passes_q <= '0;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      done_q   <= 1'b0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      passes_q <= passes_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      mem_q    <= mem_d;
    end
  end

  assign wr_ready_o = (state_q == FILL);
  assign rd_data_o  = mem_q[addr_t'(rd_ptr_q)];
  assign rd_valid_o = rd_valid;
  assign rd_last_o  = rd_last;
  assign pass_o     = pass_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

endmodule

// File: tb/tb_replay_stream_buffer.sv
// Directed + randomized bench for replay_stream_buffer; outputs compared each cycle
// against a block/queue-level reference model (words stored, words read, passes).
module tb_replay_stream_buffer;

  localparam int WRW = 64;
  localparam int RDW = 32;
  localparam int DEP = 8;
  localparam int PW  = 4;
  localparam int RAT = WRW / RDW;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           flush_i, start_i, wr_valid_i, rd_ready_i;
  logic [3:0]     len_i;
  logic [PW-1:0]  passes_i;
  logic [WRW-1:0] wr_data_i;
  logic           wr_ready_o, rd_valid_o, rd_last_o, busy_o, done_o;
  logic [RDW-1:0] rd_data_o;
  logic [PW-1:0]  pass_o;

  replay_stream_buffer #(.WR_WIDTH(WRW), .RD_WIDTH(RDW), .DEPTH(DEP), .PASS_W(PW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .start_i(start_i),
    .len_i(len_i), .passes_i(passes_i), .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .rd_last_o(rd_last_o), .pass_o(pass_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: block-level view of the buffer
  logic [RDW-1:0] m_mem [DEP];
  bit m_busy, m_filling, m_done;
  int m_len, m_passes, m_avail, m_reads;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) m_mem[i] = '0;
    m_busy = 0; m_filling = 0; m_done = 0;
    m_len = 0; m_passes = 0; m_avail = 0; m_reads = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_ready"}, wr_ready_o, 0);
    chk({tag, "_rd_valid"}, rd_valid_o, 0);
    chk({tag, "_rd_last"},  rd_last_o, 0);
    chk({tag, "_pass"},     pass_o, 0);
    chk({tag, "_busy"},     busy_o, 0);
    chk({tag, "_done"},     done_o, 0);
    chk({tag, "_rd_data"},  rd_data_o, 0);
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cycle(input bit push, input bit rdy, input bit start,
                       input int len, input int passes, input bit flush);
    logic [WRW-1:0] d;
    bit exp_v, was_busy;
    int idx, n;
    @(negedge clk_i);
    exp_v = m_busy && (!m_filling || (m_reads < m_avail));
    chk("rd_valid", rd_valid_o, exp_v);
    chk("wr_ready", wr_ready_o, m_filling);
    chk("busy", busy_o, m_busy);
    chk("done", done_o, m_done);
    if (exp_v) begin
      idx = m_reads % m_len;
      chk("rd_data", rd_data_o, m_mem[idx]);
      chk("rd_last", rd_last_o, (idx == m_len - 1));
      chk("pass", pass_o, m_reads / m_len);
    end
    d = {$urandom, $urandom};
    wr_data_i  = d;
    wr_valid_i = push;
    rd_ready_i = rdy;
    start_i    = start;
    len_i      = 4'(len);
    passes_i   = PW'(passes);
    flush_i    = flush;
    was_busy = m_busy;
    m_done   = 0;
    if (flush) begin
      m_busy = 0; m_filling = 0;
    end else begin
      if (push && m_filling) begin
        n = (m_len - m_avail < RAT) ? m_len - m_avail : RAT;
        for (int i = 0; i < n; i++) m_mem[m_avail + i] = d[i*RDW +: RDW];
        m_avail += n;
        if (m_avail == m_len) m_filling = 0;
      end
      if (exp_v && rdy) begin
        m_reads++;
        if (m_reads == m_len * m_passes) begin
          m_busy = 0; m_done = 1;
        end
      end
      if (start && !was_busy && len != 0 && passes != 0) begin
        m_busy = 1; m_filling = 1;
        m_len = len; m_passes = passes; m_avail = 0; m_reads = 0;
      end
    end
  endtask

  task automatic start_blk(input int len, input int passes);
    cycle(0, 1, 1, len, passes, 0);
  endtask

  // period 0: random push; rnd_rdy: random read-side back-pressure
  task automatic run(input int budget, input int period, input bit rnd_rdy);
    int c = 0;
    bit p, r;
    while (m_busy && c < budget) begin
      p = (period == 0) ? bit'($urandom % 2) : (c % period == 0);
      r = rnd_rdy ? bit'($urandom % 2) : 1'b1;
      cycle(p, r, 0, 0, 0, 0);
      c++;
    end
    n_chk++;
    assert (c < budget) else begin
      n_fail++;
      $error("FAIL timeout: observed %0d cycles expected < %0d", c, budget);
    end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    int c;
    model_reset();
    rst_ni = 1'b0; flush_i = 0; start_i = 0; wr_valid_i = 0; rd_ready_i = 0;
    len_i = '0; passes_i = '0; wr_data_i = '0;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;

    start_blk(8, 3);
    run(200, 1, 0);

    start_blk(5, 2);
    run(200, 1, 0);

    start_blk(8, 2);
    run(300, 3, 0);

    start_blk(7, 4);
    run(600, 0, 1);

    // flush during pass 1, then a fresh short block
    start_blk(8, 3);
    c = 0;
    while (m_reads < 10 && c < 100) begin cycle(1, 1, 0, 0, 0, 0); c++; end
    cycle(1, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 0);
    start_blk(4, 1);
    run(200, 1, 0);

    // ignored starts
    start_blk(0, 3);
    cycle(0, 1, 0, 0, 0, 0);
    start_blk(3, 0);
    cycle(0, 1, 0, 0, 0, 0);
    start_blk(6, 2);
    cycle(1, 1, 1, 2, 1, 0);
    cycle(0, 1, 0, 0, 0, 0);

    // async reset mid-FILL
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(0, 1, 0, 0, 0, 0);

    for (int k = 0; k < 5; k++) begin
      start_blk($urandom_range(1, DEP), $urandom_range(1, 3));
      run(800, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
